// File: rtl/glb_ld_dma_queue_ctrl_if.sv
// Handshake bundle between the tile start/interrupt pipeline, the load-DMA
// engine and the load-DMA queue sequencer.
interface glb_ld_dma_queue_ctrl_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int QUEUE_IDX_W = $clog2(QUEUE_DEPTH)
);
  logic                   strm_start_pulse;
  logic                   dma_done_pulse;
  logic                   dma_start_pulse;
  logic [QUEUE_IDX_W-1:0] dma_entry_idx;
  logic [QUEUE_DEPTH-1:0] dma_invalidate_pulse;
  logic                   strm_g2f_interrupt_pulse;
  logic                   busy;
  logic                   start_overrun;

  // Sequencer side.
  modport master (
    input  strm_start_pulse,
    input  dma_done_pulse,
    output dma_start_pulse,
    output dma_entry_idx,
    output dma_invalidate_pulse,
    output strm_g2f_interrupt_pulse,
    output busy,
    output start_overrun
  );

  // Tile / DMA engine side.
  modport slave (
    output strm_start_pulse,
    output dma_done_pulse,
    input  dma_start_pulse,
    input  dma_entry_idx,
    input  dma_invalidate_pulse,
    input  strm_g2f_interrupt_pulse,
    input  busy,
    input  start_overrun
  );
endinterface

// File: rtl/glb_ld_dma_queue_ctrl.sv
// Load-DMA header queue sequencer: walks valid queue entries, issues one DMA
// start per entry, waits for done, invalidates consumed entries (QUEUE mode)
// and raises the stream interrupt at the end of each sequence/pass.
module glb_ld_dma_queue_ctrl #(
  parameter int QUEUE_DEPTH = 4,
  parameter int QUEUE_IDX_W = $clog2(QUEUE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   cgra_soft_reset,
  input  logic [1:0]             cfg_ld_dma_mode,
  input  logic [QUEUE_DEPTH-1:0] cfg_entry_valid,
  glb_ld_dma_queue_ctrl_if.master dma_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_SEARCH
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_SINGLE,
    MODE_QUEUE,
    MODE_LOOP
  } mode_e;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [QUEUE_IDX_W-1:0] idx_q, idx_d;
  logic [QUEUE_IDX_W-1:0] tgt_q, tgt_d;
  logic                   tgt_found_q, tgt_found_d;
  logic                   start_q, start_d;
  logic [QUEUE_DEPTH-1:0] inval_q, inval_d;
  logic                   irq_q, irq_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;

  logic [QUEUE_IDX_W:0]   first_hit;
  logic [QUEUE_IDX_W:0]   above_hit;

  // Returns {found, index} of the lowest valid entry, optionally restricted
  // to indices strictly above cur.
  function automatic logic [QUEUE_IDX_W:0] find_valid(
    input logic [QUEUE_DEPTH-1:0] v,
    input logic [QUEUE_IDX_W-1:0] cur,
    input logic                   above
  );
    logic [QUEUE_IDX_W:0] res;
    res = '0;
    for (int unsigned i = QUEUE_DEPTH; i > 0; i--) begin
      if (v[i-1] && (!above || ((i - 1) > 32'(cur)))) begin
        res = {1'b1, QUEUE_IDX_W'(i - 1)};
      end
    end
    return res;
  endfunction

  assign first_hit = find_valid(cfg_entry_valid, idx_q, 1'b0);
  assign above_hit = find_valid(cfg_entry_valid, idx_q, 1'b1);

  // The next-target search runs in WAIT_DONE on the done cycle so the
  // completion interrupt can be registered into the SEARCH cycle; SEARCH
  // then only acts on the stored target.
  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    tgt_d       = tgt_q;
    tgt_found_d = tgt_found_q;
    start_d     = 1'b0;
    inval_d     = '0;
    irq_d       = 1'b0;
    ovr_d       = ovr_q;

    if (dma_if.strm_start_pulse && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dma_if.strm_start_pulse && (cfg_ld_dma_mode != 2'd0)) begin
          mode_d = mode_e'(cfg_ld_dma_mode);
          ovr_d  = 1'b0;
          if (cfg_ld_dma_mode == 2'd1) begin
            tgt_found_d = cfg_entry_valid[0];
            tgt_d       = '0;
          end else begin
            tgt_found_d = first_hit[QUEUE_IDX_W];
            tgt_d       = first_hit[QUEUE_IDX_W-1:0];
          end
          if (tgt_found_d) begin
            state_d = S_ISSUE;
            start_d = 1'b1;
            idx_d   = tgt_d;
          end else begin
            state_d = S_SEARCH;
            irq_d   = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (dma_if.dma_done_pulse) begin
          state_d = S_SEARCH;
          if (mode_q == MODE_QUEUE) begin
            inval_d = QUEUE_DEPTH'(1) << idx_q;
          end
          case (mode_q)
            MODE_QUEUE: begin
              tgt_found_d = above_hit[QUEUE_IDX_W];
              tgt_d       = above_hit[QUEUE_IDX_W-1:0];
              irq_d       = !above_hit[QUEUE_IDX_W];
            end
            MODE_LOOP: begin
              if (above_hit[QUEUE_IDX_W]) begin
                tgt_found_d = 1'b1;
                tgt_d       = above_hit[QUEUE_IDX_W-1:0];
              end else begin
                tgt_found_d = first_hit[QUEUE_IDX_W];
                tgt_d       = first_hit[QUEUE_IDX_W-1:0];
                irq_d       = 1'b1;
              end
            end
            default: begin
              tgt_found_d = 1'b0;
              irq_d       = 1'b1;
            end
          endcase
        end
      end

      S_SEARCH: begin
        if (tgt_found_q) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
          idx_d   = tgt_q;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; soft reset aborts, clk_en low freezes and
  // suppresses pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_OFF;
      idx_q       <= '0;
      tgt_q       <= '0;
      tgt_found_q <= 1'b0;
      start_q     <= 1'b0;
      inval_q     <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else if (cgra_soft_reset) begin
      state_q     <= S_IDLE;
      tgt_found_q <= 1'b0;
      start_q     <= 1'b0;
      inval_q     <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else if (!clk_en) begin
      start_q     <= 1'b0;
      inval_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      tgt_q       <= tgt_d;
      tgt_found_q <= tgt_found_d;
      start_q     <= start_d;
      inval_q     <= inval_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  assign dma_if.dma_start_pulse          = start_q;
  assign dma_if.dma_entry_idx            = idx_q;
  assign dma_if.dma_invalidate_pulse     = inval_q;
  assign dma_if.strm_g2f_interrupt_pulse = irq_q;
  assign dma_if.busy                     = busy_q;
  assign dma_if.start_overrun            = ovr_q;

endmodule

// File: tb/tb_glb_ld_dma_queue_ctrl.sv
// Directed bench for glb_ld_dma_queue_ctrl: a per-cycle vector table plus
// hand-written async-reset sequence.
module tb_glb_ld_dma_queue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_en;
  logic       cgra_soft_reset;
  logic [1:0] cfg_ld_dma_mode;
  logic [3:0] cfg_entry_valid;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  glb_ld_dma_queue_ctrl_if #(.QUEUE_DEPTH(4)) dif ();

  glb_ld_dma_queue_ctrl #(.QUEUE_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clk_en          (clk_en),
    .cgra_soft_reset (cgra_soft_reset),
    .cfg_ld_dma_mode (cfg_ld_dma_mode),
    .cfg_entry_valid (cfg_entry_valid),
    .dma_if          (dif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       dn;
    logic       en;
    logic       sr;
    logic [1:0] mode;
    logic [3:0] valid;
    logic       ds;
    logic [1:0] idx;
    logic [3:0] inv;
    logic       irq;
    logic       busy;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic dn, input logic en,
                              input logic sr, input logic [1:0] mode,
                              input logic [3:0] valid, input logic ds,
                              input logic [1:0] idx, input logic [3:0] inv,
                              input logic irq, input logic busy, input logic ovr);
    vec_t v;
    v.st = st; v.dn = dn; v.en = en; v.sr = sr; v.mode = mode; v.valid = valid;
    v.ds = ds; v.idx = idx; v.inv = inv; v.irq = irq; v.busy = busy; v.ovr = ovr;
    return v;
  endfunction

  // Output bundle: {ds, idx[1:0], inv[3:0], irq, busy, ovr}
  function automatic logic [9:0] outs();
    return {dif.dma_start_pulse, dif.dma_entry_idx, dif.dma_invalidate_pulse,
            dif.strm_g2f_interrupt_pulse, dif.busy, dif.start_overrun};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {ds,idx,inv,irq,busy,ovr}=%b required %b", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic dn, input logic en, input logic sr,
                       input logic [1:0] mode, input logic [3:0] valid);
    dif.strm_start_pulse = st;
    dif.dma_done_pulse   = dn;
    clk_en               = en;
    cgra_soft_reset      = sr;
    cfg_ld_dma_mode      = mode;
    cfg_entry_valid      = valid;
  endtask

  initial begin
    // Row: inputs applied for one cycle, expected outputs after that edge.
    //           st dn en sr mode  valid    ds idx  inv      irq busy ovr
    // Mode 2 queue walk over 1011, with an overrun start in flight
    vecs.push_back(mk(1, 0, 1, 0, 2'd2, 4'b1011, 1, 2'd0, 4'b0000, 0, 1, 0)); // 0
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b1011, 0, 2'd0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b1011, 0, 2'd0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b1011, 0, 2'd0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b1010, 1, 2'd1, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b1010, 0, 2'd1, 4'b0000, 0, 1, 0)); // 5
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b1010, 0, 2'd1, 4'b0010, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b1000, 1, 2'd3, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2'd2, 4'b1000, 0, 2'd3, 4'b0000, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b1000, 0, 2'd3, 4'b1000, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0000, 0, 2'd3, 4'b0000, 0, 0, 1)); // 10
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b0000, 0, 2'd3, 4'b0000, 0, 0, 1));
    // Mode 1 single with entry 0 valid, then with nothing valid
    vecs.push_back(mk(1, 0, 1, 0, 2'd1, 4'b0001, 1, 2'd0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 4'b0001, 0, 2'd0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'd1, 4'b0001, 0, 2'd0, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 4'b0001, 0, 2'd0, 4'b0000, 0, 0, 0)); // 15
    vecs.push_back(mk(1, 0, 1, 0, 2'd1, 4'b0000, 0, 2'd0, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));
    // Mode 0 start is ignored
    vecs.push_back(mk(1, 0, 1, 0, 2'd0, 4'b1111, 0, 2'd0, 4'b0000, 0, 0, 0));
    // Mode 3 loop over 0110; mode input switched to 2 after start (no effect)
    vecs.push_back(mk(1, 0, 1, 0, 2'd3, 4'b0110, 1, 2'd1, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 1, 0)); // 20
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 1, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b0110, 0, 2'd2, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 1, 2'd1, 4'b0000, 0, 1, 0)); // 25
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 1, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b0110, 0, 2'd2, 4'b0000, 1, 1, 0)); // 30
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 1, 2'd1, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 1, 0));
    // Soft reset in WAIT_DONE with a simultaneous done
    vecs.push_back(mk(0, 1, 1, 1, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0110, 0, 2'd1, 4'b0000, 0, 0, 0));
    // clk_en low for 5 cycles swallowing a done, then a real done
    vecs.push_back(mk(1, 0, 1, 0, 2'd2, 4'b0100, 1, 2'd2, 4'b0000, 0, 1, 0)); // 35
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0)); // 40
    vecs.push_back(mk(0, 0, 0, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'd2, 4'b0100, 0, 2'd2, 4'b0100, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 4'b0000, 0, 2'd2, 4'b0000, 0, 0, 0));

    // Reset
    reset_n = 1'b0;
    drive(0, 0, 1, 0, 2'd0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 check("reset_state", outs(), 10'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].dn, vecs[i].en, vecs[i].sr, vecs[i].mode, vecs[i].valid);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), outs(),
               {vecs[i].ds, vecs[i].idx, vecs[i].inv, vecs[i].irq, vecs[i].busy, vecs[i].ovr});
    end

    // Async reset while in SEARCH with pulses and overrun active
    @(negedge clk); drive(1, 0, 1, 0, 2'd2, 4'b0100);
    @(posedge clk); #1 check("ar_issue", outs(), {1'b1, 2'd2, 4'b0000, 1'b0, 1'b1, 1'b0});
    @(negedge clk); drive(1, 0, 1, 0, 2'd2, 4'b0100);
    @(posedge clk); #1 check("ar_overrun", outs(), {1'b0, 2'd2, 4'b0000, 1'b0, 1'b1, 1'b1});
    @(negedge clk); drive(0, 1, 1, 0, 2'd2, 4'b0100);
    @(posedge clk); #1 check("ar_search", outs(), {1'b0, 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1});
    #1 reset_n = 1'b0;
    #1 check("ar_async_clear", outs(), 10'b0);
    @(negedge clk);
    drive(0, 0, 1, 0, 2'd0, 4'b1111);
    reset_n = 1'b1;
    @(negedge clk); drive(1, 0, 1, 0, 2'd0, 4'b1111);
    @(posedge clk); #1 check("ar_mode0_start", outs(), 10'b0);
    @(negedge clk); drive(0, 0, 1, 0, 2'd0, 4'b1111);
    @(posedge clk); #1 check("ar_mode0_idle", outs(), 10'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glb_ld_dma_queue_ctrl.md
Name: glb_ld_dma_queue_ctrl

Overview:
Sequences the load-DMA header queue of one GLB tile. On a start pulse it walks the queue entries, issues one DMA start per valid entry, and waits for each DMA done. It then invalidates consumed entries and raises the stream interrupt pulse. It sits between the tile's registered start/interrupt pulse pipeline and the load-DMA engine inside the GLB core.

Parameters:
QUEUE_DEPTH, 4, number of load-DMA header entries
QUEUE_IDX_W, $clog2(QUEUE_DEPTH), derived, entry index width

Ports:
clk  in  1  tile clock
reset_n  in  1  asynchronous active-low reset
clk_en  in  1  FSM/counters advance only when high
cgra_soft_reset  in  1  synchronous abort to IDLE
cfg_ld_dma_mode  in  2  0 OFF, 1 SINGLE, 2 QUEUE, 3 LOOP
cfg_entry_valid  in  QUEUE_DEPTH  per-entry header valid bit, sampled live
strm_start_pulse  in  1  start request (one cycle)
dma_done_pulse  in  1  DMA engine finished current entry
dma_start_pulse  out  1  start DMA on dma_entry_idx
dma_entry_idx  out  QUEUE_IDX_W  entry being executed
dma_invalidate_pulse  out  QUEUE_DEPTH  one-hot, clears consumed entry
strm_g2f_interrupt_pulse  out  1  sequence/pass complete
busy  out  1  high outside IDLE
start_overrun  out  1  sticky: start arrived while busy

Behaviour:
- Reset: state IDLE; every output is 0, including dma_entry_idx and start_overrun; the latched mode is 0.
- All outputs are registered. Pulses last exactly one cycle.
- When clk_en=0: state and outputs hold, except that pulse outputs are forced 0. Input pulses in such cycles are lost.
- States: IDLE, ISSUE, WAIT_DONE, SEARCH.
- IDLE, strm_start_pulse at cycle T, mode!=0:
  - Latch the mode. Mode changes after T have no effect until IDLE.
  - Go to ISSUE. busy=1 from T+1.
  - For mode 1 the target is entry 0. For modes 2/3 the target is the lowest-index valid entry.
- IDLE, strm_start_pulse, mode=0: ignored.
- No target found: modes 2/3 with no valid entries, or mode 1 with entry 0 invalid.
  - strm_g2f_interrupt_pulse at T+1; return to IDLE; no dma_start.
- ISSUE:
  - dma_start_pulse=1 and dma_entry_idx=target, at T+1 for the first issue.
  - Go to WAIT_DONE. dma_entry_idx holds until the next issue.
- WAIT_DONE, dma_done_pulse at cycle D:
  - Go to SEARCH.
  - At D+1, modes 2 only: dma_invalidate_pulse[idx]=1. Modes 1 and 3 never invalidate.
- SEARCH, evaluated at D+1:
  - Mode 1: interrupt pulse at D+1, then IDLE.
  - Mode 2: next target = lowest valid index strictly greater than the current one.
    - Found: ISSUE, with dma_start at D+2.
    - Not found: interrupt pulse at D+1, then IDLE (busy=0 at D+2).
  - Mode 3: search above the current index first.
    - If none is found, wrap to the lowest valid index overall and pulse the interrupt at D+1 (once per pass).
    - If no valid entry exists at all: interrupt, then IDLE.
- Whenever the FSM returns to IDLE on completion, the interrupt pulse is issued in the same cycle as the last SEARCH.
- dma_done_pulse outside WAIT_DONE: ignored.
- strm_start_pulse while busy:
  - Ignored; start_overrun is set.
  - start_overrun stays set until the next accepted start, which clears it at T+1.
- cgra_soft_reset:
  - Forces IDLE at the next edge; no interrupt, invalidate or start pulses.
  - It has priority over a simultaneous done or start.
  - start_overrun is cleared.
- Reset asserted mid-operation: immediate asynchronous return to the reset values above.

Test Plan:
- Mode 2, valid=4'b1011, start at T: dma_start idx0 at T+1. Done at D0 → invalidate 4'b0001 at D0+1, start idx1 at D0+2. Done → invalidate 4'b0010, then start idx3. Final done at D → invalidate 4'b1000 and interrupt at D+1, busy=0 at D+2.
- Mode 1, valid=4'b0001: one start on idx0; done → interrupt next cycle, no invalidate. Repeat with valid=4'b0000 → interrupt at T+1, no dma_start.
- Mode 3, valid=4'b0110, three passes: issue order idx1, idx2, idx1, idx2, …; interrupt coincides with each SEARCH wrap; no invalidate pulses. Soft reset mid-WAIT_DONE → IDLE, no interrupt.
- Overrun: start again while in WAIT_DONE → start_overrun=1, sequence unaffected. Next accepted start clears the flag one cycle later.
- clk_en low for 5 cycles while a done pulse arrives → done lost, FSM stays in WAIT_DONE, no pulses. Done after clk_en returns → normal progress.
- Async reset_n low during SEARCH → all outputs 0 immediately. After release, mode=0 start → no response.
